ecc_stream_adapter: RTL

// - Word-stream front/back end for the 256-bit scalar-multiply core (dotProduct).
// - Assembles 32-bit input words into Px, Py, k and fires one core in_valid pulse.
// - Captures the core's Rx/Ry result and streams it back out as 32-bit words.
// - Valid/ready on both stream sides; one operation in flight at a time.

---
 rtl/ecc_stream_adapter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ecc_stream_adapter.sv
// 32-bit word-stream wrapper around the 256-bit scalar-multiply core: gathers Px/Py/k, starts the core, streams Rx/Ry back.
// Optional ECC_ZERO_SCALAR_BYPASS_EN: k==0 skips the core and returns the point at infinity (all-zero words, pt_inf=1).
module ecc_stream_adapter #(
    parameter int WORD_W = 32,
    parameter int KEY_W  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic [KEY_W-1:0]  core_Px,
    output logic [KEY_W-1:0]  core_Py,
    output logic [KEY_W-1:0]  core_k,
    output logic              core_in_valid,
    input  logic [KEY_W-1:0]  core_Rx,
    input  logic [KEY_W-1:0]  core_Ry,
    input  logic              core_out_valid,
    output logic              busy,
    output logic              pt_inf
);

    // KEY_W/WORD_W must be a power of two so the low counter bits index the word
    localparam int N     = KEY_W / WORD_W;
    localparam int IDX_W = $clog2(N);
    localparam logic [4:0] N_WORDS  = 5'(N);
    localparam logic [4:0] N2_WORDS = 5'(2 * N);
    localparam logic [4:0] LAST_IN  = 5'(3 * N - 1);
    localparam logic [4:0] LAST_OUT = 5'(2 * N - 1);

`ifdef ECC_ZERO_SCALAR_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef logic [N-1:0][WORD_W-1:0] words_t;
    typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    words_t          px_q, px_d, py_q, py_d, k_q, k_d;
    words_t          rx_q, rx_d, ry_q, ry_d;
    logic            pt_inf_q, pt_inf_d;
    logic [IDX_W-1:0] idx;

    assign idx     = cnt_q[IDX_W-1:0];
    assign core_Px = px_q;
    assign core_Py = py_q;
    assign core_k  = k_q;
    assign busy    = (state_q != LOAD);
    assign pt_inf  = pt_inf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            px_q     <= '0;
            py_q     <= '0;
            k_q      <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            pt_inf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            px_q     <= px_d;
            py_q     <= py_d;
            k_q      <= k_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            pt_inf_q <= pt_inf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        px_d          = px_q;
        py_d          = py_q;
        k_d           = k_q;
        rx_d          = rx_q;
        ry_d          = ry_q;
        pt_inf_d      = pt_inf_q;
        s_ready       = 1'b0;
        m_valid       = 1'b0;
        m_data        = '0;
        m_last        = 1'b0;
        core_in_valid = 1'b0;

        case (state_q)
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (cnt_q < N_WORDS)       px_d[idx] = s_data;
                    else if (cnt_q < N2_WORDS) py_d[idx] = s_data;
                    else                       k_d[idx]  = s_data;
                    if (cnt_q == LAST_IN) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            START: begin
                if (BYPASS_EN && k_q == '0) begin
                    rx_d     = '0;
                    ry_d     = '0;
                    pt_inf_d = 1'b1;
                    state_d  = SEND;
                end else begin
                    core_in_valid = 1'b1;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                // core result is only valid during the done pulse, so latch it here
                if (core_out_valid) begin
                    rx_d    = core_Rx;
                    ry_d    = core_Ry;
                    state_d = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_data  = (cnt_q < N_WORDS) ? rx_q[idx] : ry_q[idx];
                m_last  = (cnt_q == LAST_OUT);
                if (m_ready) begin
                    if (cnt_q == LAST_OUT) begin
                        cnt_d    = '0;
                        pt_inf_d = 1'b0;
                        state_d  = LOAD;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

endmodule
